// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, class/ALU/cause codes and the decoded entry layout.
package decode_pkg;

    // opcode[6:2] values; opcode[1:0] must be 2'b11 for a 32-bit instruction
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    // Illegal entries are tagged CL_NOP; the exception bits carry the meaning.
    typedef enum logic [3:0] {
        CL_ALU    = 4'd0,
        CL_LOAD   = 4'd1,
        CL_STORE  = 4'd2,
        CL_BRANCH = 4'd3,
        CL_JAL    = 4'd4,
        CL_JALR   = 4'd5,
        CL_LUI    = 4'd6,
        CL_AUIPC  = 4'd7,
        CL_MULDIV = 4'd8,
        CL_SYSTEM = 4'd9,
        CL_MRET   = 4'd10,
        CL_CSR    = 4'd11,
        CL_NOP    = 4'd12
    } class_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SRL   = 4'd5,
        ALU_SRA   = 4'd6,
        ALU_OR    = 4'd7,
        ALU_AND   = 4'd8,
        ALU_PASSB = 4'd9
    } alu_op_e;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        class_e      cls;
        alu_op_e     alu_op;
        logic        alu_signed;
        logic        regwrite;
        logic        exc;
        logic [3:0]  cause;
    } dec_entry_t;

    // SLT/SLTU share one op; signedness travels separately. alt selects SUB/SRA.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:         op = alt ? ALU_SUB : ALU_ADD;
            3'b001:         op = ALU_SLL;
            3'b010, 3'b011: op = ALU_SLT;
            3'b100:         op = ALU_XOR;
            3'b101:         op = alt ? ALU_SRA : ALU_SRL;
            3'b110:         op = ALU_OR;
            default:        op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I(+M) decoder producing one FIFO entry.
module decode_comb
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] inst,
    output dec_entry_t  entry
);

    logic [4:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    logic        w_ill;

    assign w_opc    = inst[6:2];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];
    assign w_imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_u  = {inst[31:12], 12'b0};
    assign w_imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_imm_sh = {27'b0, inst[24:20]};

    // Field extraction, class/ALU selection, then legality override
    always_comb begin
        entry            = '0;
        entry.rs1        = inst[19:15];
        entry.rs2        = inst[24:20];
        entry.rd         = inst[11:7];
        entry.funct3     = w_f3;
        entry.cls        = CL_NOP;
        entry.alu_op     = ALU_ADD;
        entry.alu_signed = 1'b1;
        w_ill            = 1'b0;
        if (inst[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (w_opc)
                OPC_LUI: begin
                    entry.cls = CL_LUI; entry.imm = w_imm_u; entry.rs1 = 5'd0;
                    entry.alu_op = ALU_PASSB; entry.regwrite = 1'b1;
                end
                OPC_AUIPC: begin
                    entry.cls = CL_AUIPC; entry.imm = w_imm_u; entry.regwrite = 1'b1;
                end
                OPC_JAL: begin
                    entry.cls = CL_JAL; entry.imm = w_imm_j; entry.regwrite = 1'b1;
                end
                OPC_JALR: begin
                    entry.cls = CL_JALR; entry.imm = w_imm_i; entry.regwrite = 1'b1;
                end
                OPC_BRANCH: begin
                    entry.cls = CL_BRANCH; entry.imm = w_imm_b; entry.alu_op = ALU_SUB;
                    w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
                end
                OPC_LOAD: begin
                    entry.cls = CL_LOAD; entry.imm = w_imm_i; entry.regwrite = 1'b1;
                    w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
                end
                OPC_STORE: begin
                    entry.cls = CL_STORE; entry.imm = w_imm_s;
                    w_ill = (w_f3 >= 3'b011);
                end
                OPC_OP_IMM: begin
                    entry.cls        = CL_ALU;
                    entry.imm        = w_imm_i;
                    entry.regwrite   = 1'b1;
                    entry.alu_op     = alu_from_f3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                    entry.alu_signed = (w_f3 != 3'b011);
                    if (w_f3 == 3'b001) begin
                        entry.imm = w_imm_sh;
                        w_ill     = (w_f7 != 7'b0000000);
                    end else if (w_f3 == 3'b101) begin
                        entry.imm = w_imm_sh;
                        w_ill     = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                    end
                end
                OPC_OP: begin
                    entry.cls        = CL_ALU;
                    entry.regwrite   = 1'b1;
                    entry.alu_op     = alu_from_f3(w_f3, w_f7[5]);
                    entry.alu_signed = (w_f3 != 3'b011);
                    if (w_f7 == 7'b0000001) begin
                        // funct3 selects the mul/div variant downstream
                        entry.alu_op     = ALU_ADD;
                        entry.alu_signed = 1'b1;
                        if (ENABLE_M) entry.cls = CL_MULDIV;
                        else          w_ill     = 1'b1;
                    end else if (w_f7 == 7'b0100000) begin
                        w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                    end else if (w_f7 != 7'b0000000) begin
                        w_ill = 1'b1;
                    end
                end
                OPC_MISC_MEM: begin
                    entry.cls = CL_NOP;
                end
                OPC_SYSTEM: begin
                    entry.imm = w_imm_i;
                    if (w_f3 == 3'b000) begin
                        if (inst == INST_ECALL) begin
                            entry.cls = CL_SYSTEM; entry.exc = 1'b1; entry.cause = CAUSE_ECALL;
                        end else if (inst == INST_EBREAK) begin
                            entry.cls = CL_SYSTEM; entry.exc = 1'b1; entry.cause = CAUSE_BREAK;
                        end else if (inst == INST_MRET) begin
                            entry.cls = CL_MRET;
                        end else begin
                            w_ill = 1'b1;
                        end
                    end else if (w_f3 == 3'b100) begin
                        w_ill = 1'b1;
                    end else begin
                        entry.cls = CL_CSR; entry.regwrite = 1'b1;
                    end
                end
                default: w_ill = 1'b1;
            endcase
        end
        if (w_ill) begin
            entry.cls      = CL_NOP;
            entry.alu_op   = ALU_ADD;
            entry.regwrite = 1'b0;
            entry.exc      = 1'b1;
            entry.cause    = CAUSE_ILLEGAL;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes on the way in, buffers up to two entries in order.
module decode_stage
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [3:0]       out_class,
    output logic [3:0]       out_alu_op,
    output logic             out_alu_signed,
    output logic             out_regwrite,
    output logic             out_exc,
    output logic [3:0]       out_cause,
    output logic [CNT_W-1:0] dec_count
);

    dec_entry_t       w_dec, w_head;
    dec_entry_t       r_ent [2];
    logic [31:0]      r_pc  [2];
    logic             r_wptr, r_rptr;
    logic [1:0]       r_cnt, w_cnt_nxt;
    logic             r_in_ready;
    logic             w_push, w_pop;
    logic [CNT_W-1:0] r_dec_count;

    decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
        .inst  (in_inst),
        .entry (w_dec)
    );

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_cnt != 2'd0) && out_ready;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // FIFO storage and pointers; in_ready is registered from next occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_ent[i] <= '0;
                r_pc[i]  <= '0;
            end
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_ent[r_wptr] <= w_dec;
                r_pc[r_wptr]  <= in_pc;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_cnt_nxt != 2'd2);
        end
    end

    // Consumed-entry counter; a pop counts even if flush arrives with it
    always_ff @(posedge clk) begin
        if (reset)      r_dec_count <= '0;
        else if (w_pop) r_dec_count <= r_dec_count + 1'b1;
    end

    assign w_head         = r_ent[r_rptr];
    assign in_ready       = r_in_ready;
    assign out_valid      = (r_cnt != 2'd0);
    assign out_pc         = r_pc[r_rptr];
    assign out_imm        = w_head.imm;
    assign out_rs1        = w_head.rs1;
    assign out_rs2        = w_head.rs2;
    assign out_rd         = w_head.rd;
    assign out_funct3     = w_head.funct3;
    assign out_class      = w_head.cls;
    assign out_alu_op     = w_head.alu_op;
    assign out_alu_signed = w_head.alu_signed;
    assign out_regwrite   = w_head.regwrite;
    assign out_exc        = w_head.exc;
    assign out_cause      = w_head.cause;
    assign dec_count      = r_dec_count;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected entries queued at push, checked at pop.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [3:0]  out_class, out_alu_op, out_cause;
    logic        out_alu_signed, out_regwrite, out_exc;
    logic [3:0]  dec_count;

    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [31:0] m_in_inst, m_in_pc, m_out_pc, m_out_imm;
    logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
    logic [2:0]  m_out_funct3;
    logic [3:0]  m_out_class, m_out_alu_op, m_out_cause;
    logic        m_out_alu_signed, m_out_regwrite, m_out_exc;
    logic [31:0] m_dec_count;

    decode_stage #(.ENABLE_M(1'b0), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3), .out_class(out_class),
        .out_alu_op(out_alu_op), .out_alu_signed(out_alu_signed), .out_regwrite(out_regwrite),
        .out_exc(out_exc), .out_cause(out_cause), .dec_count(dec_count)
    );

    decode_stage #(.ENABLE_M(1'b1), .CNT_W(32)) dut_m (
        .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_inst(m_in_inst), .in_pc(m_in_pc), .flush(1'b0), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .out_pc(m_out_pc), .out_imm(m_out_imm), .out_rs1(m_out_rs1),
        .out_rs2(m_out_rs2), .out_rd(m_out_rd), .out_funct3(m_out_funct3), .out_class(m_out_class),
        .out_alu_op(m_out_alu_op), .out_alu_signed(m_out_alu_signed), .out_regwrite(m_out_regwrite),
        .out_exc(m_out_exc), .out_cause(m_out_cause), .dec_count(m_dec_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  cls;
        logic [3:0]  op;
        logic        sgn;
        logic        rw;
        logic        exc;
        logic [3:0]  cause;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t mon_act, mon_exp;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [3:0] cls, input logic [3:0] op,
                                input logic sgn, input logic rw, input logic exc, input logic [3:0] cause);
        return {pc, imm, rs1, rs2, rd, f3, cls, op, sgn, rw, exc, cause};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one cycle; queue its expectation only if it will be taken
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        if (in_ready) q.push_back(e);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                mon_act = {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_funct3, out_class,
                           out_alu_op, out_alu_signed, out_regwrite, out_exc, out_cause};
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got entry pc=%h expected none", out_pc);
                end else begin
                    mon_exp = q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_fail++;
                        $display("FAIL sb_entry pc=%h: got %h expected %h", mon_exp.pc, mon_act, mon_exp);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        m_in_valid = 1'b0; m_in_inst = '0; m_in_pc = '0; m_out_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (2) cyc();

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dec_count", dec_count, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_fields", {out_rs1, out_rs2, out_rd, out_class, out_exc, out_regwrite}, 0);
        reset = 1'b0;
        cyc();

        // addi x1,x0,5 into empty stage
        out_ready = 1'b1;
        send(32'h0050_0093, 32'h100, mk(32'h100, 5, 0, 5, 1, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_rd", out_rd, 1);
        cyc();
        chk("t1_dec_count", dec_count, 1);
        chk("t1_empty", out_valid, 0);

        // backpressure: third push refused, head stable, then drain in order
        out_ready = 1'b0;
        send(32'h00A0_0113, 32'h200, mk(32'h200, 10, 0, 10, 2, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        send(32'h0020_81B3, 32'h204, mk(32'h204, 0, 1, 2, 3, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        chk("t2_in_ready_full", in_ready, 0);
        send(32'h00C0_0293, 32'h208, mk(32'h208, 12, 0, 12, 5, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        chk("t2_hold_pc", out_pc, 32'h200);
        chk("t2_hold_imm", out_imm, 10);
        cyc();
        chk("t2_hold_pc2", out_pc, 32'h200);
        chk("t2_in_ready_hold", in_ready, 0);
        out_ready = 1'b1;
        cyc();
        chk("t2_in_ready_after_pop", in_ready, 1);
        cyc();
        chk("t2_drained", out_valid, 0);

        // mul: illegal without M, MULDIV with M
        send(32'h0220_8033, 32'h300, mk(32'h300, 0, 1, 2, 0, 0, CL_NOP, ALU_ADD, 1, 0, 1, 2));
        m_in_valid = 1'b1; m_in_inst = 32'h0220_8033; m_in_pc = 32'h300;
        cyc();
        m_in_valid = 1'b0;
        chk("t3_m_valid", m_out_valid, 1);
        chk("t3_m_class", m_out_class, CL_MULDIV);
        chk("t3_m_exc", m_out_exc, 0);
        chk("t3_m_regwrite", m_out_regwrite, 1);

        // streamed directed vectors
        send(32'h0000_0073, 32'h400, mk(32'h400, 0, 0, 0, 0, 0, CL_SYSTEM, ALU_ADD, 1, 0, 1, 11));
        send(32'h0010_0073, 32'h404, mk(32'h404, 1, 0, 1, 0, 0, CL_SYSTEM, ALU_ADD, 1, 0, 1, 3));
        send(32'h3020_0073, 32'h408, mk(32'h408, 32'h302, 0, 2, 0, 0, CL_MRET, ALU_ADD, 1, 0, 0, 0));
        send(32'h4033_D313, 32'h40C, mk(32'h40C, 3, 7, 3, 6, 5, CL_ALU, ALU_SRA, 1, 1, 0, 0));
        send(32'hFFF4_B413, 32'h410, mk(32'h410, 32'hFFFF_FFFF, 9, 31, 8, 3, CL_ALU, ALU_SLT, 0, 1, 0, 0));
        send(32'h1234_5537, 32'h414, mk(32'h414, 32'h1234_5000, 0, 3, 10, 5, CL_LUI, ALU_PASSB, 1, 1, 0, 0));
        send(32'h0000_2063, 32'h418, mk(32'h418, 0, 0, 0, 0, 2, CL_NOP, ALU_ADD, 1, 0, 1, 2));
        send(32'h0000_0001, 32'h41C, mk(32'h41C, 0, 0, 0, 0, 0, CL_NOP, ALU_ADD, 1, 0, 1, 2));
        send(32'hFE20_9EE3, 32'h420, mk(32'h420, 32'hFFFF_FFFC, 1, 2, 29, 1, CL_BRANCH, ALU_SUB, 1, 0, 0, 0));
        send(32'h0FF0_000F, 32'h424, mk(32'h424, 0, 0, 31, 0, 0, CL_NOP, ALU_ADD, 1, 0, 0, 0));
        send(32'h0200_9093, 32'h428, mk(32'h428, 0, 1, 0, 1, 1, CL_NOP, ALU_ADD, 1, 0, 1, 2));
        cyc();
        chk("t4_dec_count", dec_count, 15);

        // flush with two buffered and a concurrent push
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h500, mk(32'h500, 1, 0, 1, 1, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        send(32'h0020_0093, 32'h504, mk(32'h504, 2, 0, 2, 1, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        in_valid = 1'b1; in_inst = 32'h0030_0093; in_pc = 32'h508; flush = 1'b1;
        q.delete();
        cyc();
        in_valid = 1'b0; flush = 1'b0;
        chk("t5_flush_valid", out_valid, 0);
        chk("t5_flush_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("t5_count_kept", dec_count, 15);

        // 16th pop wraps the 4-bit counter
        send(32'h0050_0093, 32'h600, mk(32'h600, 5, 0, 5, 1, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        cyc();
        chk("t6_wrap", dec_count, 0);

        // reset mid-stream loses buffered entries
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h700, mk(32'h700, 1, 0, 1, 1, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        send(32'h0020_0093, 32'h704, mk(32'h704, 2, 0, 2, 1, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        out_ready = 1'b1;
        cyc();
        chk("t7_count_pre", dec_count, 1);
        reset = 1'b1;
        q.delete();
        cyc();
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_count", dec_count, 0);
        chk("t7_rst_ready", in_ready, 1);
        chk("t7_rst_pc", out_pc, 0);
        reset = 1'b0;
        send(32'h0050_0093, 32'h710, mk(32'h710, 5, 0, 5, 1, 0, CL_ALU, ALU_ADD, 1, 1, 0, 0));
        cyc();
        chk("t7_resume_count", dec_count, 1);

        chk("sb_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ENABLE_M, default 0: 1 = decode the RV32M encodings (OP, funct7=0000001) as class MULDIV; 0 = those encodings are illegal.
REQ-002 Parameter CNT_W, default 32: width of the decoded-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  fetch presents an instruction.
REQ-006 in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 in_inst  input  32  raw instruction word.
REQ-008 in_pc  input  32  address of in_inst.
REQ-009 flush  input  1  discard all buffered and in-flight instructions.
REQ-010 out_valid  output  1  decoded entry available.
REQ-011 out_ready  input  1  execute stage consumes the entry.
REQ-012 out_pc  output  32  PC of the entry.
REQ-013 out_imm  output  32  sign/zero-extended immediate (I/U/J/B/S formats; 0 for R-type).
REQ-014 out_rs1, out_rs2, out_rd  output  5 each  register addresses; rs1 forced to 0 for LUI.
REQ-015 out_funct3  output  3  funct3 field.
REQ-016 out_class  output  4  instruction class code (from decode_pkg).
REQ-017 out_alu_op  output  4  ALU operation code (from decode_pkg).
REQ-018 out_alu_signed  output  1  0 only for SLTU/SLTIU.
REQ-019 out_regwrite  output  1  entry writes rd.
REQ-020 out_exc  output  1  entry raises an exception.
REQ-021 out_cause  output  4  exception cause code: 2 = illegal, 3 = breakpoint, 11 = ecall.
REQ-022 dec_count  output  CNT_W  count of consumed entries.

Function
REQ-023 The stage SHALL be a 2-entry in-order FIFO storing fully decoded fields; decoding SHALL occur on the input side before the write.
REQ-024 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-025 in_ready SHALL be registered (high iff fewer than 2 entries); there SHALL be no combinational path from out_ready to in_ready.
REQ-026 Latency: an instruction pushed at edge N into an empty stage SHALL give out_valid=1 with its fields during cycle N+1.
REQ-027 With 1 entry, simultaneous push and pop SHALL keep the occupancy at 1 and present the new entry next cycle.
REQ-028 With 2 entries, in_ready SHALL be 0; a pop SHALL raise in_ready on the following cycle.
REQ-029 The out_* fields SHALL remain stable while out_valid && !out_ready.
REQ-030 Flush SHALL empty both entries at the next edge and drop any push in the same cycle; the cycle after a flush SHALL have out_valid=0 and in_ready=1.
REQ-031 Illegal SHALL be set for any of:
- inst[1:0] != 11, or an unsupported opcode
- BRANCH funct3 010 or 011
- LOAD funct3 011, 110 or 111
- STORE funct3 >= 011
- SYSTEM funct3 100
- OP funct7 not 0000000/0100000 (or 0000001 with ENABLE_M=1); funct7=0100000 allowed only with funct3 000/101
- SLLI funct7 != 0; SRLI/SRAI funct7 not 0000000/0100000
- SYSTEM funct3 000 that is not ECALL, EBREAK or MRET.
REQ-032 An illegal entry SHALL still be delivered, with out_exc=1, out_cause=2 and out_regwrite=0.
REQ-033 ECALL (inst=0x00000073) SHALL give cause 11 and EBREAK (0x00100073) cause 3, both with out_regwrite=0.
REQ-034 MRET (0x30200073) SHALL give class MRET with no exception.
REQ-035 FENCE SHALL give class NOP with no exception.
REQ-036 The immediate for SLLI/SRLI/SRAI SHALL be zero-extended inst[24:20].
REQ-037 dec_count SHALL increment by 1 on each pop, wrap modulo 2^CNT_W, and be unaffected by flush.

Reset
REQ-038 Reset SHALL empty the FIFO and set out_valid=0, in_ready=1 and dec_count=0.
REQ-039 Reset SHALL drive all out_* data fields to 0.
REQ-040 Reset SHALL take priority over flush, push and pop; reset asserted mid-stream SHALL lose all entries.

Structure
REQ-041 Package decode_pkg SHALL hold the opcode constants (opcode[6:2]), the class codes, the ALU op codes, the cause codes and a packed decoded-entry struct.
REQ-042 The combinational decoder SHALL be a single sub-module, decode_comb (inputs inst, ENABLE_M; output the entry struct), instantiated once.
REQ-043 FIFO control (pointers, count) SHALL be local to decode_stage.

Verification
REQ-044 Push 0x00500093 (addi x1,x0,5) into an empty stage with out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rd=1, out_alu_op=ADD, out_regwrite=1, and dec_count=1 after that cycle.
REQ-045 Hold out_ready=0 and push 3 instructions back-to-back -> in_ready=0 after the 2nd push, the 3rd is not accepted, and outputs are stable; then release out_ready -> entries emerge in PC order.
REQ-046 Push 0x02208033 (mul) with ENABLE_M=0 -> out_exc=1, cause=2, regwrite=0; with ENABLE_M=1 -> class MULDIV, out_exc=0.
REQ-047 Push 0x00000073, then 0x00100073, then 0x30200073 -> causes 11, 3, then class MRET with out_exc=0.
REQ-048 With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flushed instructions never appear.
REQ-049 Preset 2^CNT_W-1 pops (CNT_W=4: 15), then pop once more -> dec_count=0; assert reset mid-stream -> out_valid=0 and dec_count=0 the next cycle.
